// File: rtl/difftest_pkg.sv
// difftest_pkg: commit record layout and widths shared by the difftest queues
package difftest_pkg;
  localparam int INDEX_W = 8;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        is_TLBFILL;
    logic [4:0]  TLBFILL_index;
    logic        is_CNTinst;
    logic [63:0] timer_64_value;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        csr_rstat;
    logic [31:0] csr_data;
  } commit_rec_t;
  localparam int REC_W = $bits(commit_rec_t);
endpackage

// File: rtl/commit_compactor.sv
// commit_compactor: packs the valid lanes of a retire group into the low slots, in lane order
module commit_compactor
  import difftest_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]                 i_valid,
  input  commit_rec_t [W-1:0]          i_rec,
  output commit_rec_t [W-1:0]          o_rec,
  output logic [$clog2(W+1)-1:0]       o_cnt
);
  localparam int IW = W > 1 ? $clog2(W) : 1;
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] w_cnt;
  // each valid lane lands in the next free slot; the running count is the popcount
  always_comb begin
    o_rec = '0;
    w_cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (i_valid[i]) begin
        o_rec[w_cnt[IW-1:0]] = i_rec[i];
        w_cnt = w_cnt + CW'(1);
      end
    end
  end
  assign o_cnt = w_cnt;
endmodule

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: compacting circular commit-trace buffer feeding the difftest probes
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int COMMIT_W = 4,
  parameter int DRAIN_W  = 4,
  parameter int DEPTH    = 16
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [COMMIT_W-1:0]               i_in_valid,
  input  commit_rec_t [COMMIT_W-1:0]        i_in_rec,
  output logic                              o_in_ready,
  input  logic                              i_drain_en,
  output logic [DRAIN_W-1:0]                o_out_valid,
  output commit_rec_t [DRAIN_W-1:0]         o_out_rec,
  output logic [DRAIN_W-1:0][INDEX_W-1:0]   o_out_index,
  output logic [DRAIN_W-1:0][63:0]          o_out_seq,
  output logic [$clog2(DEPTH):0]            o_occupancy,
  output logic                              o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(COMMIT_W + 1);
  localparam int DW = $clog2(DRAIN_W + 1);
  commit_rec_t                 r_mem [DEPTH];
  logic [63:0]                 r_seq_mem [DEPTH];
  logic [PW-1:0]               r_head, r_tail;
  logic [OW-1:0]               r_occ;
  logic [63:0]                 r_seq_cnt;
  logic                        r_overflow;
  logic [DRAIN_W-1:0]          r_out_valid;
  commit_rec_t [DRAIN_W-1:0]   r_out_rec;
  logic [DRAIN_W-1:0][63:0]    r_out_seq;
  commit_rec_t [COMMIT_W-1:0]  w_crec;
  logic [CW-1:0]               w_cnt, w_push;
  logic [DW-1:0]               w_pop;
  logic [OW-1:0]               w_free;
  logic                        w_ready;
  commit_compactor #(.W(COMMIT_W)) u_compactor (
    .i_valid (i_in_valid),
    .i_rec   (i_in_rec),
    .o_rec   (w_crec),
    .o_cnt   (w_cnt)
  );
  assign w_free  = OW'(DEPTH) - r_occ;
  assign w_ready = w_free >= OW'(COMMIT_W);
  assign w_push  = w_ready ? w_cnt : '0;
  assign w_pop   = i_drain_en ? (r_occ < OW'(DRAIN_W) ? DW'(r_occ) : DW'(DRAIN_W)) : '0;
  // store compacted records with their sequence numbers at tail; a reset-cycle burst is dropped
  always_ff @(posedge i_clock)
    if (!i_reset)
      for (int k = 0; k < COMMIT_W; k++)
        if (CW'(k) < w_push) begin
          r_mem[r_tail + PW'(k)]     <= w_crec[k];
          r_seq_mem[r_tail + PW'(k)] <= r_seq_cnt + 64'(k);
        end
  // pointers, occupancy, sequence counter, sticky overflow and the drain output registers
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_seq_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= '0;
      r_out_rec   <= '0;
      r_out_seq   <= '0;
    end else begin
      r_tail     <= r_tail + PW'(w_push);
      r_head     <= r_head + PW'(w_pop);
      r_occ      <= r_occ + OW'(w_push) - OW'(w_pop);
      r_seq_cnt  <= r_seq_cnt + 64'(w_push);
      r_overflow <= r_overflow | ((|i_in_valid) & ~w_ready);
      for (int k = 0; k < DRAIN_W; k++) begin
        r_out_valid[k] <= DW'(k) < w_pop;
        if (DW'(k) < w_pop) begin
          r_out_rec[k] <= r_mem[r_head + PW'(k)];
          r_out_seq[k] <= r_seq_mem[r_head + PW'(k)];
        end
      end
    end
  for (genvar i = 0; i < DRAIN_W; i++) begin : g_idx
    assign o_out_index[i] = INDEX_W'(i);
  end
  assign o_in_ready  = w_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_rec   = r_out_rec;
  assign o_out_seq   = r_out_seq;
  assign o_occupancy = r_occ;
  assign o_overflow  = r_overflow;
endmodule
